sm83_srlatch_strobe_ctl: RTL and testbench
==========================================

// Module: sm83_srlatch_strobe_ctl
// PURPOSE
// Clocked driver for the write side of an active-low-reset SR latch cell (s, r_n in; q out).
// Accepts set/clear commands over a valid/ready handshake and issues a single s or r_n strobe of fixed width.
// Waits a settle window and samples the latch q feedback, then reports done with a pass/fail flag.
// Sits between the sequencer test harness and any SR latch instance that needs deterministic, glitch-free strobes.
// PARAMETERS
// PULSE_CYCLES   2   width of the s (high) or r_n (low) strobe in clk cycles; legal range 1..15
// SETTLE_CYCLES  3   cycles after strobe release before q_fb is sampled; legal range 0..15
// PORTS
// clk       in   1  rising-edge clock
// reset_n   in   1  synchronous, active-low reset
// cmd_valid in   1  command offered
// cmd_set   in   1  1 = set latch (q -> 1), 0 = clear latch (q -> 0); valid only with cmd_valid
// cmd_ready out  1  controller can accept a command this cycle
// s         out  1  set strobe to latch, active high
// r_n       out  1  reset strobe to latch, active low
// q_fb      in   1  latch q feedback (treated as synchronous to clk)
// done      out  1  one-cycle pulse: command completed
// ok        out  1  valid with done: 1 = q_fb matched cmd_set at sample point
// busy      out  1  command in flight (any state except IDLE)
// BEHAVIOUR
// Reset (reset_n=0 at a clk edge): state=IDLE, s=0, r_n=1, done=0, ok=0, busy=0, cmd_ready=1 after release; counters=0.
// Reset mid-command: abort immediately at that edge; strobes deasserted same edge; no done pulse is emitted.
// States: IDLE -> STROBE -> SETTLE -> CHECK -> IDLE.
// IDLE: cmd_ready=1. Accept when cmd_valid&cmd_ready at a clk edge; latch cmd_set into cmd_q; go STROBE; cnt=PULSE_CYCLES-1.
// STROBE: if cmd_q: s=1, r_n=1; else s=0, r_n=0. Decrement cnt each cycle; at cnt==0 go SETTLE, cnt=SETTLE_CYCLES.
//   Strobe is asserted exactly PULSE_CYCLES cycles, beginning the cycle after acceptance (registered outputs).
// SETTLE: s=0, r_n=1 (hold state). If cnt==0 go CHECK, else decrement. SETTLE_CYCLES=0 -> SETTLE lasts 1 cycle.
// CHECK: one cycle; done=1, ok=(q_fb==cmd_q) sampled this cycle; next state IDLE.
// Acceptance-to-done latency = 1 + PULSE_CYCLES + max(SETTLE_CYCLES,0)+1 cycles; PULSE=2,SETTLE=3 -> done 7 cycles after accept edge.
// cmd_ready=0 in STROBE/SETTLE/CHECK; back-to-back: a command offered during CHECK is accepted in the following IDLE cycle (min 1 idle cycle).
// Invariant: never s=1 together with r_n=0 (latch resolves to q=0, r_n dominant); s and r_n are never both active in any cycle.
// Outputs s, r_n, done, ok are driven from flops only; no combinational path from cmd_* or q_fb to s/r_n.
// ok is 0 whenever done=0. busy = (state != IDLE).
// cmd_valid dropped while cmd_ready=0 has no effect; cmd_set changes after acceptance are ignored.
// Redundant commands (set when q already 1) still strobe and check normally.
// TESTING
// Reset: hold reset_n=0 2 cycles with cmd_valid=1 -> s=0, r_n=1, cmd_ready=0... then 1 after release, no done, no strobe.
// Set: accept cmd_set=1 at T0, latch model tied -> s=1 on cycles T1..T2, done=1 ok=1 at T7; r_n stays 1 throughout.
// Clear: q_fb=1 initially, accept cmd_set=0 -> r_n=0 for exactly 2 cycles, s=0 always, done=1 ok=1 7 cycles later.
// Fault: q_fb forced to 0 during set command -> done=1 with ok=0 at T7; controller returns to IDLE, cmd_ready=1 at T8.
// Abort: reset_n=0 during STROBE of a clear -> r_n=1 next edge, no done pulse, next command completes normally.
// Back-to-back + invariant: cmd_valid held high with alternating cmd_set for 10 commands -> each spaced 8 cycles, assertion (s & ~r_n)==0 never fires.

Source files
------------

// File: rtl/sm83_srlatch_strobe_ctl.sv
// ---------------------------------------------------------------------------
// sm83_srlatch_strobe_ctl
//
// Purpose:
//   Write-side driver for an SR latch cell with an active-low reset input.
//   A set or clear command is accepted over a valid/ready handshake. The
//   controller then issues one fixed-width strobe: s high for a set, or r_n
//   low for a clear. It waits a settle window and samples the latch q
//   feedback. Finally it pulses done, with ok reporting whether q matched
//   the request.
//
// Parameters:
//   PULSE_CYCLES   strobe width in clk cycles (1..15)
//   SETTLE_CYCLES  cycles between strobe release and the check cycle (0..15)
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   cmd_valid  in   command offered
//   cmd_set    in   1 = set latch, 0 = clear latch
//   cmd_ready  out  controller can accept a command this cycle
//   s          out  set strobe to latch, active high (registered)
//   r_n        out  reset strobe to latch, active low (registered)
//   q_fb       in   latch q feedback, synchronous to clk
//   done       out  one-cycle completion pulse (registered)
//   ok         out  with done: q_fb matched the command (registered)
//   busy       out  command in flight
// ---------------------------------------------------------------------------
module sm83_srlatch_strobe_ctl #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r_n,
  input  logic q_fb,
  output logic done,
  output logic ok,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic       cmd_q;
  logic       next_cmd;
  logic       accept;
  logic       next_strobe;

  // cmd_ready is gated by reset_n so that no handshake is offered while
  // reset is held.
  assign cmd_ready = (state == IDLE) && reset_n;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Next-state logic. The counter is loaded with N-1 for the strobe, so the
  // STROBE state lasts exactly PULSE_CYCLES cycles. It is loaded with N for
  // the settle window, so SETTLE lasts SETTLE_CYCLES+1 cycles. That gives at
  // least one SETTLE cycle even when SETTLE_CYCLES is 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_cmd   = cmd_q;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = STROBE;
          next_cnt   = PULSE_LOAD;
          next_cmd   = cmd_set;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          next_state = SETTLE;
          next_cnt   = SETTLE_LOAD;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          next_state = CHECK;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      CHECK: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The strobe flops are loaded from the next state, so the strobe lines up
  // with the STROBE state. This keeps the outputs glitch-free, with no
  // combinational path from cmd_* or q_fb. Only one of s / ~r_n can be
  // active, because both derive from the same next_cmd bit.
  assign next_strobe = (next_state == STROBE);

  // State register and registered outputs. done/ok are produced by the
  // CHECK cycle and appear in the cycle after it, which is the first IDLE
  // cycle. A reset in mid-command therefore never leaves a done pulse
  // behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cmd_q <= 1'b0;
      s     <= 1'b0;
      r_n   <= 1'b1;
      done  <= 1'b0;
      ok    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      cmd_q <= next_cmd;
      s     <= next_strobe && next_cmd;
      r_n   <= !(next_strobe && !next_cmd);
      done  <= (state == CHECK);
      ok    <= (state == CHECK) && (q_fb == cmd_q);
    end
  end

endmodule

// File: tb/tb_sm83_srlatch_strobe_ctl.sv
// ---------------------------------------------------------------------------
// tb_sm83_srlatch_strobe_ctl
//
// Directed bench for the SR latch strobe controller. A behavioural latch
// (r_n dominant) drives q_fb. The latch output can be overridden to model
// a stuck cell.
// ---------------------------------------------------------------------------
module tb_sm83_srlatch_strobe_ctl;

  logic clk = 1'b0;
  logic reset_n;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic s;
  logic r_n;
  logic q_fb;
  logic done;
  logic ok;
  logic busy;

  logic q_latch    = 1'b0;
  logic force_en   = 1'b0;
  logic force_val  = 1'b0;
  logic inv_active = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sm83_srlatch_strobe_ctl #(
    .PULSE_CYCLES (2),
    .SETTLE_CYCLES(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_set  (cmd_set),
    .cmd_ready(cmd_ready),
    .s        (s),
    .r_n      (r_n),
    .q_fb     (q_fb),
    .done     (done),
    .ok       (ok),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Latch model: reset input dominates set.
  always @(posedge clk) begin
    if (!r_n)   q_latch <= 1'b0;
    else if (s) q_latch <= 1'b1;
  end

  assign q_fb = force_en ? force_val : q_latch;

  // Strobe-exclusivity invariant, watched on every falling edge.
  always @(negedge clk) begin
    if (inv_active) begin
      n_checks++;
      assert ((s & ~r_n) === 1'b0)
      else begin
        n_fail++;
        $error("[TB] FAIL strobe_excl: observed s=%0b r_n=%0b expected never s=1 with r_n=0", s, r_n);
      end
    end
  end

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and track it through all eight post-accept cycles.
  // Index k means the cycle that follows accept edge T0 + k.
  task automatic run_cmd(input logic set, input logic exp_ok, input logic hold_valid, input string name);
    logic exp_s, exp_rn, exp_done, exp_busy;
    cmd_valid = 1'b1;
    cmd_set   = set;
    step();
    if (!hold_valid) begin
      cmd_valid = 1'b0;
      cmd_set   = ~set;
    end
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      exp_s    = set && (k <= 1);
      exp_rn   = !(!set && (k <= 1));
      exp_done = (k == 7);
      exp_busy = (k <= 6);
      check_output($sformatf("%s_s_k%0d", name, k), {7'd0, s}, {7'd0, exp_s});
      check_output($sformatf("%s_rn_k%0d", name, k), {7'd0, r_n}, {7'd0, exp_rn});
      check_output($sformatf("%s_done_k%0d", name, k), {7'd0, done}, {7'd0, exp_done});
      check_output($sformatf("%s_busy_k%0d", name, k), {7'd0, busy}, {7'd0, exp_busy});
      check_output($sformatf("%s_ok_k%0d", name, k), {7'd0, ok}, {7'd0, exp_done && exp_ok});
    end
    check_output($sformatf("%s_ready_after", name), {7'd0, cmd_ready}, 8'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_set   = 1'b1;
    inv_active = 1'b1;

    // Reset held two cycles while a command is offered.
    step();
    step();
    check_output("rst_s", {7'd0, s}, 8'd0);
    check_output("rst_rn", {7'd0, r_n}, 8'd1);
    check_output("rst_ready", {7'd0, cmd_ready}, 8'd0);
    check_output("rst_done", {7'd0, done}, 8'd0);
    check_output("rst_busy", {7'd0, busy}, 8'd0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    check_output("rel_ready", {7'd0, cmd_ready}, 8'd1);
    step();
    check_output("rel_s", {7'd0, s}, 8'd0);
    check_output("rel_done", {7'd0, done}, 8'd0);
    check_output("rel_q", {7'd0, q_latch}, 8'd0);

    // Set: latch goes to 1.
    run_cmd(1'b1, 1'b1, 1'b0, "set");
    step();
    check_output("set_done_clear", {7'd0, done}, 8'd0);
    check_output("set_q", {7'd0, q_latch}, 8'd1);

    // Clear from q=1.
    run_cmd(1'b0, 1'b1, 1'b0, "clr");
    step();
    check_output("clr_q", {7'd0, q_latch}, 8'd0);

    // Stuck-at-0 feedback during a set reports ok=0.
    force_en  = 1'b1;
    force_val = 1'b0;
    run_cmd(1'b1, 1'b0, 1'b0, "fault");
    force_en = 1'b0;
    step();

    // Abort a clear during STROBE: strobe released at the reset edge, no done.
    cmd_valid = 1'b1;
    cmd_set   = 1'b0;
    step();
    cmd_valid = 1'b0;
    check_output("abort_rn_active", {7'd0, r_n}, 8'd0);
    reset_n = 1'b0;
    step();
    check_output("abort_rn", {7'd0, r_n}, 8'd1);
    check_output("abort_s", {7'd0, s}, 8'd0);
    check_output("abort_busy", {7'd0, busy}, 8'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_output($sformatf("abort_nodone_%0d", k), {7'd0, done}, 8'd0);
    end
    run_cmd(1'b1, 1'b1, 1'b0, "post_abort");

    // Back-to-back: valid held high, cmd_set alternating, accepts 8 cycles apart.
    for (int i = 0; i < 10; i++) begin
      run_cmd((i % 2) == 0 ? 1'b0 : 1'b1, 1'b1, 1'b1, $sformatf("b2b%0d", i));
    end
    cmd_valid = 1'b0;
    step();

    inv_active = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
